rv32_muldiv: RTL and testbench

- Iterative RV32M multiply/divide unit between the register-file read ports and the register-file write port.
- Consumes the two source operands plus funct3 and the destination index, and computes over multiple cycles.
- Returns the result as a write strobe, index and data that drive the register file's rfwr/rfrd/rfD directly.
- The core holds issue while busy is high.

---
 rtl/rv32_muldiv_pkg.sv | 25 ++
 rtl/rv32_div_iter.sv | 42 ++++
 rtl/rv32_muldiv.sv | 157 +++++++++++++++
 tb/tb_rv32_muldiv.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/rv32_muldiv_pkg.sv
// Shared definitions for the RV32M iterative multiply/divide unit:
// funct3 opcodes, FSM state encoding, word width and divide-by-zero quotient.
package rv32_muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] OP_MUL    = 3'd0;
  localparam logic [2:0] OP_MULH   = 3'd1;
  localparam logic [2:0] OP_MULHSU = 3'd2;
  localparam logic [2:0] OP_MULHU  = 3'd3;
  localparam logic [2:0] OP_DIV    = 3'd4;
  localparam logic [2:0] OP_DIVU   = 3'd5;
  localparam logic [2:0] OP_REM    = 3'd6;
  localparam logic [2:0] OP_REMU   = 3'd7;

  localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/rv32_div_iter.sv
// Restoring divider datapath on operand magnitudes. One quotient bit per
// step; the parent sequences the steps and applies sign correction.
module rv32_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            load,
  input  logic            step,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] quo,
  output logic [XLEN-1:0] rem
);

  logic [XLEN-1:0] dvsr;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   diff;

  // Trial subtraction of the divisor from the shifted partial remainder
  always_comb begin
    trial = {rem, quo[XLEN-1]};
    diff  = trial - {1'b0, dvsr};
  end

  // Load magnitudes, then shift in one quotient bit per step (restore on borrow)
  always_ff @(posedge clk) begin
    if (load) begin
      quo  <= dividend;
      rem  <= '0;
      dvsr <= divisor;
    end else if (step) begin
      if (!diff[XLEN]) begin
        rem <= diff[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b1};
      end else begin
        rem <= trial[XLEN-1:0];
        quo <= {quo[XLEN-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/rv32_muldiv.sv
// RV32M iterative multiply/divide unit. Result drives the register-file
// write port (wb_wr/wb_rd/wb_data). Optional macro MULDIV_FAST_MUL_EN
// replaces the iterative multiply with a single-cycle product.
module rv32_muldiv #(
  parameter int XLEN  = rv32_muldiv_pkg::XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic            wb_wr,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
);
  import rv32_muldiv_pkg::*;

  function automatic logic [XLEN-1:0] cneg_w(input logic [XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] cneg_dw(input logic [2*XLEN-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  a_mag_q;
  logic [2*XLEN-1:0] acc;

  logic             a_neg, b_neg, neg_in;
  logic [XLEN-1:0]  a_mag_in, b_mag_in;
  logic             special, accept, div_step;
  logic [XLEN-1:0]  special_res, fix_res, quo, rem;
  logic [XLEN:0]    mul_sum;
  logic [2*XLEN-1:0] prod;

  assign busy   = (state != IDLE);
  assign wb_wr  = done && (wb_rd != 5'd0);
  assign accept = (state == IDLE) && start && !flush;

  // Operand decode on issue: signedness, magnitudes, result sign, special divides
  always_comb begin
    a_neg       = rs1_val[XLEN-1] & (op[2] ? ~op[0] : (op != OP_MULHU));
    b_neg       = rs2_val[XLEN-1] & (op[2] ? ~op[0] : ~op[1]);
    a_mag_in    = cneg_w(rs1_val, a_neg);
    b_mag_in    = cneg_w(rs2_val, b_neg);
    neg_in      = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
    special     = 1'b0;
    special_res = '0;
    if (op[2] && (rs2_val == '0)) begin
      special     = 1'b1;
      special_res = op[1] ? rs1_val : DIV_ZERO_Q;
    end else if ((op == OP_DIV || op == OP_REM) &&
                 (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end
  end

  // Shift-add step and sign-corrected result selection
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag_q} : '0);
    prod    = cneg_dw(acc, neg_q);
    if (op_q[2])
      fix_res = op_q[1] ? cneg_w(rem, neg_q) : cneg_w(quo, neg_q);
    else
      fix_res = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  end

  assign div_step = (state == CALC) && op_q[2] && !flush;

  rv32_div_iter #(.XLEN(XLEN)) u_div (
    .clk      (clk),
    .load     (accept && op[2]),
    .step     (div_step),
    .dividend (a_mag_in),
    .divisor  (b_mag_in),
    .quo      (quo),
    .rem      (rem)
  );

  // Multiply datapath: load magnitudes on issue, accumulate one bit per CALC edge
  always_ff @(posedge clk) begin
    if (accept) begin
      a_mag_q <= a_mag_in;
`ifdef MULDIV_FAST_MUL_EN
      acc     <= (2*XLEN)'(a_mag_in) * (2*XLEN)'(b_mag_in);
`else
      acc     <= {{XLEN{1'b0}}, b_mag_in};
`endif
    end else if (state == CALC && !op_q[2]) begin
      acc <= {mul_sum, acc[XLEN-1:1]};
    end
  end

  // Control FSM with registered done/writeback outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      done    <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      op_q    <= OP_MUL;
      neg_q   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            wb_rd <= rd_in;
            op_q  <= op;
            neg_q <= neg_in;
            cnt   <= '0;
            if (special) begin
              wb_data <= special_res;
              done    <= 1'b1;
              state   <= DONE;
            end
`ifdef MULDIV_FAST_MUL_EN
            else if (!op[2]) state <= FIX;
`endif
            else state <= CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (cnt == CNT_W'(XLEN-1)) state <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            wb_data <= fix_res;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32_muldiv.sv
// Directed testbench for rv32_muldiv with hand-computed expected results.
module tb_rv32_muldiv;
  import rv32_muldiv_pkg::*;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif
  localparam int LAT_DIV = 33;
  localparam int LAT_SPC = 0;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  op;
  logic [31:0] rs1_val, rs2_val;
  logic [4:0]  rd_in;
  logic        busy, done, wb_wr;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks   = 0;
  int errors   = 0;
  int done_cnt = 0;
  int dc0;

  rv32_muldiv dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .wb_wr   (wb_wr),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    op = o; rs1_val = a; rs2_val = b; rd_in = rd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rs1_val = ~a; rs2_val = ~b; rd_in = ~rd;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " data"}, wb_data, exp);
    check({tag, " wr"}, {31'd0, wb_wr}, {31'd0, rd != 5'd0});
    check({tag, " rd"}, {27'd0, wb_rd}, {27'd0, rd});
    @(posedge clk); #1;
    check({tag, " idle"}, {30'd0, busy, done}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = OP_MUL;
    rs1_val = '0; rs2_val = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset done", {31'd0, done}, 32'd0);
    check("reset wr", {31'd0, wb_wr}, 32'd0);
    check("reset rd", {27'd0, wb_rd}, 32'd0);
    check("reset data", wb_data, 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op("mul",      OP_MUL,    32'h0000_0007, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, LAT_MUL);
    run_op("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6, 32'hFFFF_FFFE, LAT_MUL);
    run_op("mulh",     OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'h0000_0000, LAT_MUL);
    run_op("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 5'd8, 32'hFFFF_FFFF, LAT_MUL);
    run_op("mulh_min", OP_MULH,   32'h8000_0000, 32'h8000_0000, 5'd9, 32'h4000_0000, LAT_MUL);
    run_op("div",      OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 5'd10, 32'hFFFF_FFFD, LAT_DIV);
    run_op("rem",      OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 5'd11, 32'hFFFF_FFFF, LAT_DIV);
    run_op("divu",     OP_DIVU,   32'd100,       32'd7,         5'd12, 32'd14,        LAT_DIV);
    run_op("remu",     OP_REMU,   32'd100,       32'd7,         5'd13, 32'd2,         LAT_DIV);
    run_op("div0",     OP_DIV,    32'h0000_1234, 32'h0,         5'd14, 32'hFFFF_FFFF, LAT_SPC);
    run_op("remu0",    OP_REMU,   32'h0000_1234, 32'h0,         5'd15, 32'h0000_1234, LAT_SPC);
    run_op("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, LAT_SPC);
    run_op("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'h0000_0000, LAT_SPC);
    run_op("divu_big", OP_DIVU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h0000_0000, LAT_DIV);
    run_op("remu_big", OP_REMU,   32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, LAT_DIV);
    run_op("mul_rd0",  OP_MUL,    32'd3,         32'd4,         5'd0,  32'd12,        LAT_MUL);

    // flush mid-divide: aborted op never pulses done, next op runs normally
    dc0 = done_cnt;
    @(negedge clk);
    op = OP_DIV; rs1_val = 32'hFFFF_FFF9; rs2_val = 32'd2; rd_in = 5'd3; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush busy", {31'd0, busy}, 32'd0);
    repeat (4) @(posedge clk);
    run_op("after_flush", OP_DIVU, 32'd100, 32'd7, 5'd4, 32'd14, LAT_DIV);
    check("flush done count", done_cnt, dc0 + 1);

    // flush together with start in IDLE: nothing accepted
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd9; rs2_val = 32'd3; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1; start = 1'b0; flush = 1'b0;
    check("flush+start busy", {31'd0, busy}, 32'd0);

    // start while busy is ignored
    @(negedge clk);
    op = OP_REMU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd21; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    op = OP_MUL; rs1_val = 32'd3; rs2_val = 32'd4; rd_in = 5'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    begin
      int n = 0;
      while (!done && n < 60) begin @(posedge clk); #1; n++; end
      check("busy_start lat", n, LAT_DIV - 11);
    end
    check("busy_start data", wb_data, 32'd2);
    check("busy_start rd", {27'd0, wb_rd}, 32'd21);
    repeat (2) @(posedge clk);

    // reset mid-CALC aborts with no done and clears outputs
    @(negedge clk);
    op = OP_DIVU; rs1_val = 32'd100; rs2_val = 32'd7; rd_in = 5'd22; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    dc0 = done_cnt;
    check("rst busy", {31'd0, busy}, 32'd0);
    check("rst done", {31'd0, done}, 32'd0);
    check("rst data", wb_data, 32'd0);
    check("rst rd", {27'd0, wb_rd}, 32'd0);
    repeat (40) @(posedge clk);
    #1;
    check("rst no done", done_cnt, dc0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
